// File: rtl/game_sequencer.sv
// Round controller for the block game: level latch, lives, round timer and result screens.
// Define GAME_SEQ_AUTO_ADVANCE_EN to advance to the next level after a win instead of returning to IDLE.
module game_sequencer #(
  parameter int HOLD_FRAMES    = 120,
  parameter int LIVES          = 3,
  parameter int TIMEOUT_FRAMES = 1800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        update,
  input  logic        start,
  input  logic        levelselect1,
  input  logic        levelselect2,
  input  logic        win,
  input  logic        game_over,
  output logic [1:0]  level,
  output logic        round_rst,
  output logic        play_en,
  output logic        show_win,
  output logic        show_lose,
  output logic        show_over,
  output logic [1:0]  lives,
  output logic [10:0] time_left
);

  localparam int HW = $clog2(HOLD_FRAMES + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_FRAMES - 1);
  localparam logic [1:0]    LIVES_V   = 2'(LIVES);
  localparam logic [10:0]   TIMEOUT_V = 11'(TIMEOUT_FRAMES);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PLAY,
    WIN_HOLD,
    LOSE_HOLD,
    OVER
  } state_t;

  state_t state, nxt;

  logic          start_meta, start_sync, start_prev, start_p;
  logic [HW-1:0] hold_cnt;
  logic          hold_done;
  logic [1:0]    level_sel;

  // Two-flop synchronizer followed by a registered rising-edge detector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_meta <= 1'b0;
      start_sync <= 1'b0;
      start_prev <= 1'b0;
      start_p    <= 1'b0;
    end else begin
      start_meta <= start;
      start_sync <= start_meta;
      start_prev <= start_sync;
      start_p    <= start_sync & ~start_prev;
    end
  end

  always_comb begin
    if (!levelselect1 && !levelselect2)
      level_sel = 2'd0;
    else if (levelselect1 && !levelselect2)
      level_sel = 2'd1;
    else
      level_sel = 2'd2;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt       = state;
    hold_done = update && (hold_cnt == HOLD_LAST);
    case (state)
      IDLE:      if (start_p) nxt = LOAD;
      LOAD:      if (update) nxt = PLAY;
      PLAY: begin
        if (game_over)
          nxt = LOSE_HOLD;
        else if (win)
          nxt = WIN_HOLD;
        else if (update && time_left == 11'd1)
          nxt = LOSE_HOLD;
      end
      WIN_HOLD: begin
        if (hold_done) begin
`ifdef GAME_SEQ_AUTO_ADVANCE_EN
          nxt = (level < 2'd2) ? LOAD : IDLE;
`else
          nxt = IDLE;
`endif
        end
      end
      LOSE_HOLD: if (hold_done) nxt = (lives != 2'd0) ? LOAD : OVER;
      OVER:      if (start_p) nxt = IDLE;
      default:   nxt = IDLE;
    endcase
  end

  // Round bookkeeping; the timer freezes on a loss or win so the result screen shows the final value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level     <= 2'd0;
      lives     <= LIVES_V;
      time_left <= TIMEOUT_V;
      hold_cnt  <= '0;
    end else begin
      if (state == IDLE && start_p)
        level <= level_sel;
`ifdef GAME_SEQ_AUTO_ADVANCE_EN
      else if (state == WIN_HOLD && nxt == LOAD)
        level <= level + 2'd1;
`endif

      if (nxt == IDLE)
        lives <= LIVES_V;
      else if (state == PLAY && nxt == LOSE_HOLD && lives != 2'd0)
        lives <= lives - 2'd1;

      if (nxt == LOAD)
        time_left <= TIMEOUT_V;
      else if (state == PLAY && update && !game_over && !win && time_left != 11'd0)
        time_left <= time_left - 11'd1;

      if (nxt != state)
        hold_cnt <= '0;
      else if (update && (state == WIN_HOLD || state == LOSE_HOLD))
        hold_cnt <= hold_cnt + 1'b1;
    end
  end

  // Mode flags are registered from the next state so they switch on the transition edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      round_rst <= 1'b1;
      play_en   <= 1'b0;
      show_win  <= 1'b0;
      show_lose <= 1'b0;
      show_over <= 1'b0;
    end else begin
      round_rst <= (nxt == IDLE) || (nxt == LOAD);
      play_en   <= (nxt == PLAY);
      show_win  <= (nxt == WIN_HOLD);
      show_lose <= (nxt == LOSE_HOLD);
      show_over <= (nxt == OVER);
    end
  end

endmodule

// File: tb/tb_game_sequencer.sv
// Directed testbench for game_sequencer: level latch, losses, timeout, win exit and async reset.
module tb_game_sequencer;

  logic        clk = 1'b0;
  logic        rst, update, start, levelselect1, levelselect2, win, game_over;
  logic [1:0]  level, lives;
  logic        round_rst, play_en, show_win, show_lose, show_over;
  logic [10:0] time_left;

  int n_checks = 0;
  int n_fail   = 0;

  game_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .update       (update),
    .start        (start),
    .levelselect1 (levelselect1),
    .levelselect2 (levelselect2),
    .win          (win),
    .game_over    (game_over),
    .level        (level),
    .round_rst    (round_rst),
    .play_en      (play_en),
    .show_win     (show_win),
    .show_lose    (show_lose),
    .show_over    (show_over),
    .lives        (lives),
    .time_left    (time_left)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic frame();
    update = 1'b1;
    tick(1);
    update = 1'b0;
    tick(2);
  endtask

  task automatic frames(input int n);
    repeat (n) frame();
  endtask

  task automatic press_start();
    start = 1'b1;
    tick(2);
    start = 1'b0;
    tick(4);
  endtask

  initial begin
    rst = 1'b1; update = 1'b0; start = 1'b0;
    levelselect1 = 1'b0; levelselect2 = 1'b0; win = 1'b0; game_over = 1'b0;
    tick(2);
    check_output("rst_round_rst", 32'(round_rst), 32'd1);
    check_output("rst_play_en",   32'(play_en),   32'd0);
    check_output("rst_lives",     32'(lives),     32'd3);
    check_output("rst_time_left", 32'(time_left), 32'd1800);
    check_output("rst_level",     32'(level),     32'd0);
    check_output("rst_show",      32'({show_win, show_lose, show_over}), 32'd0);
    rst = 1'b0;
    tick(1);

    // Level 1 start, enter LOAD then PLAY
    levelselect1 = 1'b1;
    press_start();
    check_output("load_level",     32'(level),     32'd1);
    check_output("load_round_rst", 32'(round_rst), 32'd1);
    check_output("load_play_en",   32'(play_en),   32'd0);
    frame();
    check_output("play_en",        32'(play_en),   32'd1);
    check_output("play_round_rst", 32'(round_rst), 32'd0);
    check_output("play_time_left", 32'(time_left), 32'd1800);

    // Start and switch changes during PLAY are ignored
    levelselect1 = 1'b0; levelselect2 = 1'b1;
    press_start();
    check_output("ign_start_play",  32'(play_en),   32'd1);
    check_output("ign_start_level", 32'(level),     32'd1);
    frame();
    check_output("play_decrement",  32'(time_left), 32'd1799);

    // win and game_over together: loss wins priority
    win = 1'b1; game_over = 1'b1;
    tick(1);
    win = 1'b0; game_over = 1'b0;
    check_output("prio_show_lose", 32'(show_lose), 32'd1);
    check_output("prio_show_win",  32'(show_win),  32'd0);
    check_output("prio_lives",     32'(lives),     32'd2);
    check_output("prio_play_en",   32'(play_en),   32'd0);
    check_output("prio_time_hold", 32'(time_left), 32'd1799);
    frames(119);
    check_output("hold119_lose", 32'(show_lose), 32'd1);
    frame();
    check_output("reload_show_lose", 32'(show_lose), 32'd0);
    check_output("reload_round_rst", 32'(round_rst), 32'd1);
    check_output("reload_level",     32'(level),     32'd1);
    check_output("reload_time_left", 32'(time_left), 32'd1800);
    check_output("reload_lives",     32'(lives),     32'd2);

    // Second loss
    frame();
    check_output("play2_en", 32'(play_en), 32'd1);
    game_over = 1'b1;
    tick(1);
    game_over = 1'b0;
    check_output("loss2_lives", 32'(lives), 32'd1);
    frames(120);
    check_output("loss2_reload", 32'(round_rst), 32'd1);

    // Third loss by timeout
    frame();
    check_output("play3_time", 32'(time_left), 32'd1800);
    frames(1799);
    check_output("timeout_last_frame", 32'(time_left), 32'd1);
    check_output("timeout_still_play", 32'(play_en),   32'd1);
    frame();
    check_output("timeout_zero",  32'(time_left), 32'd0);
    check_output("timeout_lose",  32'(show_lose), 32'd1);
    check_output("timeout_lives", 32'(lives),     32'd0);
    frames(120);
    check_output("over_show",  32'(show_over), 32'd1);
    check_output("over_lose",  32'(show_lose), 32'd0);
    check_output("over_lives", 32'(lives),     32'd0);
    press_start();
    check_output("idle_lives",     32'(lives),     32'd3);
    check_output("idle_show_over", 32'(show_over), 32'd0);
    check_output("idle_round_rst", 32'(round_rst), 32'd1);

    // Win on level 0
    levelselect1 = 1'b0; levelselect2 = 1'b0;
    press_start();
    check_output("lvl0_level", 32'(level), 32'd0);
    frame();
    win = 1'b1;
    tick(1);
    win = 1'b0;
    check_output("win0_show",  32'(show_win), 32'd1);
    check_output("win0_lives", 32'(lives),    32'd3);
    frames(120);
    check_output("win0_exit_show", 32'(show_win),  32'd0);
    check_output("win0_exit_rrst", 32'(round_rst), 32'd1);
`ifdef GAME_SEQ_AUTO_ADVANCE_EN
    check_output("win0_exit_level", 32'(level), 32'd1);
    frame();
    check_output("win0_next_play", 32'(play_en), 32'd1);
`else
    check_output("win0_exit_level", 32'(level), 32'd0);
    frame();
    check_output("win0_next_play", 32'(play_en), 32'd0);
`endif
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(1);

    // Win on level 2 always returns to IDLE
    levelselect1 = 1'b1; levelselect2 = 1'b1;
    press_start();
    check_output("lvl2_level", 32'(level), 32'd2);
    frame();
    win = 1'b1;
    tick(1);
    win = 1'b0;
    check_output("win2_show", 32'(show_win), 32'd1);
    frames(120);
    check_output("win2_exit_show",  32'(show_win),  32'd0);
    check_output("win2_exit_level", 32'(level),     32'd2);
    frame();
    check_output("win2_idle_play",  32'(play_en),   32'd0);
    check_output("win2_idle_rrst",  32'(round_rst), 32'd1);

    // Asynchronous reset in the middle of a win hold
    press_start();
    frame();
    win = 1'b1;
    tick(1);
    win = 1'b0;
    frames(60);
    check_output("mid_hold_show", 32'(show_win), 32'd1);
    rst = 1'b1;
    #1;
    check_output("async_show_win",  32'(show_win),  32'd0);
    check_output("async_round_rst", 32'(round_rst), 32'd1);
    check_output("async_level",     32'(level),     32'd0);
    tick(1);
    rst = 1'b0;
    frame();
    check_output("async_idle_play", 32'(play_en), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
